// File: rtl/poly_voice_mixer.sv
// poly_voice_mixer: NUM_VOICES-voice oscillator bank with note allocation,
// oldest-voice stealing and a sequential per-voice mixer. Each sample_tick
// advances the active phases, sums one voice per cycle, then registers the mix.

// Per-voice waveform generator: turns one phase into a scaled signed sample.
module poly_voice_wave #(
    parameter int PHASE_W = 24,
    parameter int AMP_W   = 16
) (
    input  logic [PHASE_W-1:0]      phase,
    input  logic [1:0]              wave_sel,
    input  logic [AMP_W-1:0]        amplitude,
    output logic signed [AMP_W:0]   sample
);

    logic [AMP_W-1:0]          p;
    logic [AMP_W-1:0]          t;
    logic signed [AMP_W-1:0]   n;
    logic signed [AMP_W:0]     amp_s;
    logic signed [2*AMP_W-1:0] prod;
    logic                      unused_bits;

    // Saw and triangle share one centred ramp and one multiplier; square is +/- amplitude.
    always_comb begin
        p     = phase[PHASE_W-1 -: AMP_W];
        t     = phase[PHASE_W-2 -: AMP_W];
        if (phase[PHASE_W-1])
            t = ~t;
        amp_s = {1'b0, amplitude};
        // Subtracting 2^(AMP_W-1) from an unsigned AMP_W value is an MSB flip.
        if (wave_sel == 2'b01)
            n = {~p[AMP_W-1], p[AMP_W-2:0]};
        else
            n = {~t[AMP_W-1], t[AMP_W-2:0]};
        // |n*amp| < 2^(2*AMP_W-1), so 2*AMP_W signed bits hold the product exactly.
        prod = n * amp_s;
        case (wave_sel)
            2'b00:   sample = phase[PHASE_W-1] ? -amp_s : amp_s;
            2'b01,
            2'b10:   sample = prod[2*AMP_W-1 -: AMP_W+1];  // arithmetic >>> (AMP_W-1)
            default: sample = '0;
        endcase
    end

    // Low product bits and the sub-sample phase bits are intentionally dropped.
    assign unused_bits = ^{prod, phase};

endmodule

module poly_voice_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 24,
    parameter int AMP_W      = 16,
    parameter int OUT_W      = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    note_on,
    input  logic                    note_off,
    input  logic [3:0]              note,
    input  logic [2:0]              octave,
    input  logic [PHASE_W-1:0]      phase_inc,
    input  logic [1:0]              wave_sel,
    input  logic [AMP_W-1:0]        amplitude,
    input  logic                    sample_tick,
    output logic signed [OUT_W-1:0] wave_out,
    output logic                    wave_valid,
    output logic [NUM_VOICES-1:0]   voices_active,
    output logic                    voice_stolen,
    output logic                    sample_overrun
);

    localparam int KEY_W = 7;
    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MIX,
        ST_OUT
    } state_t;

    // Voice table
    logic [NUM_VOICES-1:0]              v_active;
    logic [NUM_VOICES-1:0][KEY_W-1:0]   v_key;
    logic [NUM_VOICES-1:0][PHASE_W-1:0] v_inc;
    logic [NUM_VOICES-1:0][PHASE_W-1:0] v_phase;
    logic [NUM_VOICES-1:0][IDX_W-1:0]   v_age;
    logic [NUM_VOICES-1:0][AMP_W:0]     v_sample;

    // Allocation
    logic [KEY_W-1:0]      key_in;
    logic [NUM_VOICES-1:0] key_hit;
    logic                  hit_found;
    logic                  free_found;
    logic [IDX_W-1:0]      hit_idx;
    logic [IDX_W-1:0]      free_idx;
    logic [IDX_W-1:0]      old_idx;
    logic [IDX_W-1:0]      old_age;
    logic [IDX_W-1:0]      alloc_idx;
    logic                  steal;

    // Mixer
    state_t                  state;
    logic [IDX_W-1:0]        mix_idx;
    logic signed [OUT_W-1:0] acc;
    logic signed [OUT_W-1:0] acc_next;
    logic [AMP_W:0]          mix_samp;
    logic                    tick_adv;

    assign key_in        = {octave, note};
    assign voices_active = v_active;
    assign tick_adv      = sample_tick && (state == ST_IDLE);

    // One waveform generator per voice; the mixer picks one per MIX cycle.
    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        poly_voice_wave #(
            .PHASE_W (PHASE_W),
            .AMP_W   (AMP_W)
        ) u_wave (
            .phase     (v_phase[g]),
            .wave_sel  (wave_sel),
            .amplitude (amplitude),
            .sample    (v_sample[g])
        );
    end

    // Pick the target voice: same-key retrigger, else lowest free, else oldest.
    always_comb begin
        hit_found  = 1'b0;
        free_found = 1'b0;
        hit_idx    = '0;
        free_idx   = '0;
        old_idx    = '0;
        old_age    = '0;
        key_hit    = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            key_hit[v] = v_active[v] && (v_key[v] == key_in);
            if (key_hit[v] && !hit_found) begin
                hit_found = 1'b1;
                hit_idx   = IDX_W'(v);
            end
            if (!v_active[v] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(v);
            end
            // Strictly-greater keeps the lowest index on an age tie.
            if (v_age[v] > old_age) begin
                old_age = v_age[v];
                old_idx = IDX_W'(v);
            end
        end
        steal = !hit_found && !free_found;
        if (hit_found)
            alloc_idx = hit_idx;
        else if (free_found)
            alloc_idx = free_idx;
        else
            alloc_idx = old_idx;
    end

    // Voice table update: phase advance on an accepted tick, then note events.
    // A note_on landing with a tick wins for its own voice (phase restarts at 0).
    always_ff @(posedge clk) begin
        if (reset) begin
            v_active     <= '0;
            v_key        <= '0;
            v_inc        <= '0;
            v_phase      <= '0;
            v_age        <= '0;
            voice_stolen <= 1'b0;
        end else begin
            voice_stolen <= note_on && steal;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (tick_adv && v_active[v])
                    v_phase[v] <= v_phase[v] + v_inc[v];
                if (note_on) begin
                    if (alloc_idx == IDX_W'(v)) begin
                        v_active[v] <= 1'b1;
                        v_key[v]    <= key_in;
                        v_inc[v]    <= phase_inc;
                        v_phase[v]  <= '0;
                        v_age[v]    <= '0;
                    end else if (v_active[v] && (v_age[v] != IDX_MAX)) begin
                        v_age[v] <= v_age[v] + 1'b1;
                    end
                end else if (note_off && key_hit[v]) begin
                    v_active[v] <= 1'b0;
                end
            end
        end
    end

    // Live read of the voice under mix; inactive voices contribute nothing.
    always_comb begin
        mix_samp = v_sample[mix_idx];
        acc_next = acc;
        if (v_active[mix_idx])
            acc_next = acc + {{(OUT_W-AMP_W-1){mix_samp[AMP_W]}}, mix_samp};
    end

    // Mixer FSM: IDLE waits for a tick, MIX sums one voice per cycle, OUT holds the valid pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            mix_idx        <= '0;
            acc            <= '0;
            wave_out       <= '0;
            wave_valid     <= 1'b0;
            sample_overrun <= 1'b0;
        end else begin
            wave_valid     <= 1'b0;
            sample_overrun <= sample_tick && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (sample_tick) begin
                        acc     <= '0;
                        mix_idx <= '0;
                        state   <= ST_MIX;
                    end
                end
                ST_MIX: begin
                    acc <= acc_next;
                    if (mix_idx == IDX_MAX) begin
                        // Registering here makes wave_valid visible during OUT.
                        wave_out   <= acc_next;
                        wave_valid <= 1'b1;
                        state      <= ST_OUT;
                    end else begin
                        mix_idx <= mix_idx + 1'b1;
                    end
                end
                ST_OUT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Scoreboard bench for poly_voice_mixer: each sample_tick pushes the expected
// mix and its due cycle; a negedge monitor pops and checks on wave_valid.
module tb_poly_voice_mixer;

    localparam int NV = 4;
    localparam int PW = 16;
    localparam int AW = 8;
    localparam int OW = 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 note_on = 1'b0;
    logic                 note_off = 1'b0;
    logic [3:0]           note = '0;
    logic [2:0]           octave = '0;
    logic [PW-1:0]        phase_inc = '0;
    logic [1:0]           wave_sel = '0;
    logic [AW-1:0]        amplitude = '0;
    logic                 sample_tick = 1'b0;
    logic signed [OW-1:0] wave_out;
    logic                 wave_valid;
    logic [NV-1:0]        voices_active;
    logic                 voice_stolen;
    logic                 sample_overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        string tag;
        int    val;
        int    due;
    } exp_t;
    exp_t sb[$];

    poly_voice_mixer #(
        .NUM_VOICES (NV),
        .PHASE_W    (PW),
        .AMP_W      (AW),
        .OUT_W      (OW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .note_on        (note_on),
        .note_off       (note_off),
        .note           (note),
        .octave         (octave),
        .phase_inc      (phase_inc),
        .wave_sel       (wave_sel),
        .amplitude      (amplitude),
        .sample_tick    (sample_tick),
        .wave_out       (wave_out),
        .wave_valid     (wave_valid),
        .voices_active  (voices_active),
        .voice_stolen   (voice_stolen),
        .sample_overrun (sample_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: every wave_valid must match the oldest outstanding tick.
    always @(negedge clk) begin
        exp_t e;
        if (wave_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_wave_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk(e.tag, int'(wave_out), e.val);
                chk({e.tag, "_latency"}, cyc, e.due);
            end
        end
    end

    task automatic key_ev(input bit on, input bit off, input logic [6:0] key,
                          input logic [PW-1:0] inc);
        {octave, note} = key;
        phase_inc      = inc;
        note_on        = on;
        note_off       = off;
        @(posedge clk); #1;
        note_on  = 1'b0;
        note_off = 1'b0;
    endtask

    task automatic tick(input string tag, input int exp);
        sample_tick = 1'b1;
        sb.push_back('{tag, exp, cyc + NV + 1});
        @(posedge clk); #1;
        sample_tick = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_wave_out", int'(wave_out), 0);
        chk("rst_wave_valid", wave_valid, 0);
        chk("rst_active", voices_active, 0);
        chk("rst_stolen", voice_stolen, 0);
        chk("rst_overrun", sample_overrun, 0);

        // 1: single square voice
        amplitude = 8'd100;
        wave_sel  = 2'b00;
        key_ev(1, 0, 7'h25, 16'h4000);
        chk("t1_active", voices_active, 4'b0001);
        tick("t1_sq_pos", 100);
        drain();
        tick("t1_sq_neg", -100);
        drain();
        chk("t1_active_hold", voices_active, 4'b0001);

        // 2: saw and triangle at phase 0x4000 (retrigger restarts the phase)
        key_ev(1, 0, 7'h25, 16'h4000);
        chk("t2_no_steal", voice_stolen, 0);
        chk("t2_active", voices_active, 4'b0001);
        wave_sel = 2'b01;
        tick("t2_saw", -50);
        drain();
        key_ev(1, 0, 7'h25, 16'h4000);
        wave_sel = 2'b10;
        tick("t2_tri", 0);
        drain();

        // 3: four voices, then release voice 2
        do_reset();
        amplitude = 8'd10;
        wave_sel  = 2'b00;
        for (int k = 0; k < 4; k++)
            key_ev(1, 0, 7'(8'h10 + k), 16'h4000);
        chk("t3_active4", voices_active, 4'b1111);
        tick("t3_poly4", 40);
        drain();
        key_ev(0, 1, 7'h12, 16'h0000);
        chk("t3_off_active", voices_active, 4'b1011);
        tick("t3_after_off", -30);
        drain();

        // 4: refill voice 2, steal oldest (voice 0), retrigger voice 1
        key_ev(1, 0, 7'h12, 16'h4000);
        chk("t4_refill_no_steal", voice_stolen, 0);
        chk("t4_refill_active", voices_active, 4'b1111);
        key_ev(1, 0, 7'h20, 16'h8000);
        chk("t4_stolen", voice_stolen, 1);
        chk("t4_steal_active", voices_active, 4'b1111);
        @(posedge clk); #1;
        chk("t4_stolen_pulse", voice_stolen, 0);
        tick("t4_steal_mix", -20);
        drain();
        key_ev(1, 0, 7'h11, 16'h8000);
        chk("t4_retrig_no_steal", voice_stolen, 0);
        chk("t4_retrig_active", voices_active, 4'b1111);
        tick("t4_retrig_mix", 0);
        drain();

        // 5: simultaneous on/off, absent-key off
        key_ev(0, 1, 7'h13, 16'h0000);
        chk("t5_off_v3", voices_active, 4'b0111);
        key_ev(1, 1, 7'h13, 16'h4000);
        chk("t5_on_wins", voices_active, 4'b1111);
        chk("t5_on_wins_no_steal", voice_stolen, 0);
        key_ev(0, 1, 7'h7F, 16'h0000);
        chk("t5_absent_off", voices_active, 4'b1111);

        // 6: overrun while mixing, then reset mid-mix
        amplitude = 8'd20;
        wave_sel  = 2'b01;
        tick("t6_saw_mix", -20);
        @(posedge clk); #1;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        chk("t6_overrun", sample_overrun, 1);
        drain();
        repeat (8) @(posedge clk);
        #1;
        chk("t6_overrun_clear", sample_overrun, 0);
        chk("t6_wave_hold", int'(wave_out), -20);

        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t6_rst_wave_out", int'(wave_out), 0);
        chk("t6_rst_valid", wave_valid, 0);
        chk("t6_rst_active", voices_active, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("t6_rst_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
